arm_regfile_sb: RTL and testbench



---
 rtl/arm_pkg.sv | 11 +
 rtl/arm_regfile_sb_if.sv | 36 +++
 rtl/arm_sb_counter.sv | 46 ++++
 rtl/arm_regfile_sb.sv | 120 ++++++++++++
 tb/tb_arm_regfile_sb.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared defaults and index type for the ARM register file slice.
package arm_pkg;

  localparam int unsigned ArmDataW   = 32;
  localparam int unsigned ArmNumRegs = 16;
  localparam int unsigned ArmAddrW   = $clog2(ArmNumRegs);
  localparam int unsigned ArmPcIdx   = ArmNumRegs - 1;

  typedef logic [ArmAddrW-1:0] reg_idx_t;

endpackage

// File: rtl/arm_regfile_sb_if.sv
// ID-stage register file bus: read ports, PC, write-back and issue tracking.
interface arm_regfile_sb_if
  import arm_pkg::*;
#(
    parameter int unsigned DATA_W = ArmDataW,
    parameter int unsigned ADDR_W = ArmAddrW
);

    logic [ADDR_W-1:0] rd_addr1;
    logic              rd_use1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_use2;
    logic [DATA_W-1:0] pc_in;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              hazard;
    logic              iss_full;

    modport master (
        output rd_addr1, rd_use1, rd_addr2, rd_use2, pc_in,
        output wb_en, wb_addr, wb_data, iss_en, iss_addr,
        input  rd_data1, rd_data2, hazard, iss_full
    );

    modport slave (
        input  rd_addr1, rd_use1, rd_addr2, rd_use2, pc_in,
        input  wb_en, wb_addr, wb_data, iss_en, iss_addr,
        output rd_data1, rd_data2, hazard, iss_full
    );

endinterface

// File: rtl/arm_sb_counter.sv
// Pending-write counter for one register: inc and dec together hold, inc at max and
// dec at zero hold.
module arm_sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic is_zero_o,
    output logic is_one_o,
    output logic is_max_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign is_zero_o = (cnt_q == '0);
    assign is_one_o  = (cnt_q == CNT_W'(1));
    assign is_max_o  = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !is_max_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i && !is_zero_o) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A write-back with nothing outstanding means the pipeline lost track of a destination.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(dec_i && !inc_i && is_zero_o))
            else $error("arm_sb_counter: write-back with no pending write");
        end
    end

endmodule

// File: rtl/arm_regfile_sb.sv
// ID-stage register file with write-through bypass, PC substitution and a per-register
// pending-write scoreboard for local RAW hazard detection.
module arm_regfile_sb
  import arm_pkg::*;
#(
    parameter int unsigned DATA_W   = ArmDataW,
    parameter int unsigned NUM_REGS = ArmNumRegs,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    arm_regfile_sb_if.slave    bus
);

    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
    localparam int unsigned PC_IDX   = NUM_REGS - 1;
    localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX);
    localparam bit BypassEn = (BYPASS != 0);

    logic [ADDR_W-1:0] rd_addr1, rd_addr2, wb_addr, iss_addr;
    logic              rd_use1, rd_use2, wb_en, iss_en;
    logic [DATA_W-1:0] pc_in, wb_data;
    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic              hazard, iss_full;

    assign rd_addr1 = bus.rd_addr1;
    assign rd_use1  = bus.rd_use1;
    assign rd_addr2 = bus.rd_addr2;
    assign rd_use2  = bus.rd_use2;
    assign pc_in    = bus.pc_in;
    assign wb_en    = bus.wb_en;
    assign wb_addr  = bus.wb_addr;
    assign wb_data  = bus.wb_data;
    assign iss_en   = bus.iss_en;
    assign iss_addr = bus.iss_addr;

    assign bus.rd_data1 = rd_data1;
    assign bus.rd_data2 = rd_data2;
    assign bus.hazard   = hazard;
    assign bus.iss_full = iss_full;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_addr != PcAddr) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        if (rd_addr1 == PcAddr) begin
            rd_data1 = pc_in;
        end else if (BypassEn && wb_en && wb_addr == rd_addr1) begin
            rd_data1 = wb_data;
        end
    end

    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        if (rd_addr2 == PcAddr) begin
            rd_data2 = pc_in;
        end else if (BypassEn && wb_en && wb_addr == rd_addr2) begin
            rd_data2 = wb_data;
        end
    end

    // The PC has no counter: it reads as permanently idle and never saturates.
    logic [NUM_REGS-2:0] sb_inc, sb_dec;
    logic [NUM_REGS-1:0] is_zero, is_one, is_max;

    assign is_zero[PC_IDX] = 1'b1;
    assign is_one[PC_IDX]  = 1'b0;
    assign is_max[PC_IDX]  = 1'b0;

    for (genvar r = 0; r < int'(PC_IDX); r++) begin : g_sb
        assign sb_inc[r] = iss_en && !iss_full && iss_addr == ADDR_W'(r);
        assign sb_dec[r] = wb_en && wb_addr == ADDR_W'(r);

        arm_sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc_i     (sb_inc[r]),
            .dec_i     (sb_dec[r]),
            .is_zero_o (is_zero[r]),
            .is_one_o  (is_one[r]),
            .is_max_o  (is_max[r])
        );
    end

    assign iss_full = !rst && iss_en && is_max[iss_addr] && !(wb_en && wb_addr == iss_addr);

    logic pend1, pend2;

    // A lone outstanding write landing this cycle is already visible through the bypass.
    always_comb begin
        pend1 = !is_zero[rd_addr1] &&
                !(BypassEn && wb_en && wb_addr == rd_addr1 && is_one[rd_addr1]);
        pend2 = !is_zero[rd_addr2] &&
                !(BypassEn && wb_en && wb_addr == rd_addr2 && is_one[rd_addr2]);
        hazard = !rst && ((rd_use1 && rd_addr1 != PcAddr && pend1) ||
                          (rd_use2 && rd_addr2 != PcAddr && pend2));
    end

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Directed plus randomized check of arm_regfile_sb against an array/counter reference model.
module tb_arm_regfile_sb;
    import arm_pkg::*;

    localparam int NR = 16;
    localparam int PC = 15;
    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arm_regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    arm_regfile_sb #(
        .DATA_W   (32),
        .NUM_REGS (16),
        .CNT_W    (2),
        .BYPASS   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] m_regs [NR];
    int          m_cnt  [NR];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        if (a == PC) return bus.pc_in;
        if (bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input int a);
        if (m_cnt[a] == 0) return 1'b0;
        if (bus.wb_en && int'(bus.wb_addr) == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_hazard();
        int a1 = int'(bus.rd_addr1);
        int a2 = int'(bus.rd_addr2);
        if (rst) return 1'b0;
        return (bus.rd_use1 && a1 != PC && exp_pend(a1)) ||
               (bus.rd_use2 && a2 != PC && exp_pend(a2));
    endfunction

    function automatic logic exp_full();
        int ia = int'(bus.iss_addr);
        if (rst) return 1'b0;
        return bus.iss_en && ia != PC && m_cnt[ia] == MAXC &&
               !(bus.wb_en && int'(bus.wb_addr) == ia);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd1"}, bus.rd_data1, exp_rd(int'(bus.rd_addr1)));
        check({tag, ".rd2"}, bus.rd_data2, exp_rd(int'(bus.rd_addr2)));
        check({tag, ".hazard"}, 32'(bus.hazard), 32'(exp_hazard()));
        check({tag, ".full"}, 32'(bus.iss_full), 32'(exp_full()));
    endtask

    // Commit one clock edge into the model using the inputs currently applied.
    task automatic model_edge();
        bit full = exp_full();
        int ia = int'(bus.iss_addr);
        int wa = int'(bus.wb_addr);
        bit inc = bus.iss_en && !full && ia != PC;
        bit dec = bus.wb_en && wa != PC;
        if (bus.wb_en && wa != PC) m_regs[wa] = bus.wb_data;
        if (!(inc && dec && ia == wa)) begin
            if (inc) m_cnt[ia]++;
            if (dec && m_cnt[wa] > 0) m_cnt[wa]--;
        end
    endtask

    task automatic step(input string tag, input int a1, input bit u1, input int a2, input bit u2,
                        input logic [31:0] pc, input bit wen, input int wa,
                        input logic [31:0] wd, input bit ien, input int ia);
        bus.rd_addr1 = 4'(a1);
        bus.rd_use1  = u1;
        bus.rd_addr2 = 4'(a2);
        bus.rd_use2  = u2;
        bus.pc_in    = pc;
        bus.wb_en    = wen;
        bus.wb_addr  = 4'(wa);
        bus.wb_data  = wd;
        bus.iss_en   = ien;
        bus.iss_addr = 4'(ia);
        #3;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        model_clear();
        bus.rd_addr1 = 4'd3;
        bus.rd_use1  = 1'b1;
        bus.rd_addr2 = 4'd15;
        bus.rd_use2  = 1'b1;
        bus.pc_in    = 32'h100;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        #2;
        check_all("reset");
        check("reset.r3", bus.rd_data1, 32'h0);
        check("reset.r15", bus.rd_data2, 32'h100);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Bypass and storage of a single write.
        step("iss5", 5, 0, 15, 0, 32'h100, 0, 0, 0, 1, 5);
        step("wb5", 5, 1, 15, 0, 32'h100, 1, 5, 32'hDEADBEEF, 0, 0);
        check("wb5.byp", bus.rd_data1, 32'hDEADBEEF);
        step("rd5", 5, 1, 15, 0, 32'h104, 0, 0, 0, 0, 0);

        // RAW hazard on r2, cleared by the resolving write-back.
        step("iss2", 0, 0, 0, 0, 32'h108, 0, 0, 0, 1, 2);
        step("haz2", 2, 1, 0, 0, 32'h10c, 0, 0, 0, 0, 0);
        step("wb2", 2, 1, 0, 0, 32'h110, 1, 2, 32'd7, 0, 0);

        // Saturate r4, refuse the fourth issue, accept issue alongside a write-back.
        for (int k = 0; k < 3; k++) step("iss4", 4, 1, 4, 0, 32'h114, 0, 0, 0, 1, 4);
        step("full4", 4, 1, 0, 0, 32'h118, 0, 0, 0, 1, 4);
        step("full4wb", 4, 1, 0, 0, 32'h11c, 1, 4, 32'h44, 1, 4);
        for (int k = 0; k < 3; k++) step("drain4", 4, 1, 4, 1, 32'h120, 1, 4, 32'(k), 0, 0);
        step("idle4", 4, 1, 4, 1, 32'h124, 0, 0, 0, 0, 0);

        // Writes to the PC index touch neither storage nor scoreboard.
        step("wb15", 15, 1, 15, 1, 32'h200, 1, 15, 32'h55, 0, 0);
        step("rd15", 15, 1, 3, 1, 32'h204, 0, 0, 0, 1, 15);

        for (int i = 0; i < 400; i++) begin
            int a1 = $urandom_range(0, 15);
            int a2 = $urandom_range(0, 15);
            int ia = $urandom_range(0, 15);
            bit ien = 1'($urandom_range(0, 1));
            bit wen = 1'b0;
            int wa = 0;
            if ($urandom_range(0, 3) != 0) begin
                int s = $urandom_range(0, 14);
                for (int k = 0; k < 15; k++) begin
                    int r = (s + k) % 15;
                    if (!wen && m_cnt[r] > 0) begin
                        wen = 1'b1;
                        wa = r;
                    end
                end
            end
            if (!wen && $urandom_range(0, 15) == 0) begin
                wen = 1'b1;
                wa = PC;
            end
            step("rand", a1, 1'($urandom_range(0, 1)), a2, 1'($urandom_range(0, 1)), $urandom(),
                 wen, wa, $urandom(), ien, ia);
        end

        // Drain outstanding writes so the reset case starts from a known scoreboard.
        for (int r = 0; r < 15; r++) begin
            while (m_cnt[r] > 0) step("drain", r, 1, 0, 0, 32'h300, 1, r, 32'(r), 0, 0);
        end

        // Reset in the middle of outstanding issues.
        step("iss1a", 1, 1, 5, 0, 32'h400, 0, 0, 0, 1, 1);
        step("iss1b", 1, 1, 5, 0, 32'h404, 0, 0, 0, 1, 1);
        bus.iss_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_clear();
        check_all("midrst");
        check("midrst.haz", 32'(bus.hazard), 32'h0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("post1", 1, 1, 5, 1, 32'h408, 0, 0, 0, 0, 0);
        check("post1.r5", bus.rd_data2, 32'h0);
        step("post2", 1, 1, 2, 1, 32'h40c, 0, 0, 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
